// File: rtl/wdt_reset_sequencer_if.sv
// CSR bus bundle for the watchdog reset sequencer on the shared 5-bit CPLD bus.
// The slave is always ready: a write completes in the clk where csr_we is sampled high, and csr_do follows csr_a combinationally.
interface wdt_reset_sequencer_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input csr_do);
  modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/wdt_reset_sequencer.sv
// Watchdog-bite recovery sequencer: timed reset pulse, hold-off window, retry counting, failsafe boot latch.
// Optional build macro RSTSEQ_PWRCYCLE_EN: bites after failsafe is latched request a power cycle instead of a reset.
module wdt_reset_sequencer #(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter logic [7:0] PULSE_TICKS   = 8'd10,
  parameter logic [7:0] HOLDOFF_TICKS = 8'd50,
  parameter logic [2:0] MAX_RETRIES   = 3'd3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ce,
  input  logic                        i_pwr_is_off,
  input  logic                        i_bite_strobe,
  wdt_reset_sequencer_if.slave        csr_bus,
  output logic                        o_sys_rst_req,
  output logic                        o_boot_failsafe,
  output logic                        o_pwr_cycle_req,
  output logic                        o_irq,
  output logic [1:0]                  o_dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ASSERT  = 2'b01;
  localparam logic [1:0] ST_HOLDOFF = 2'b10;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_tick_cnt;
  logic [7:0] w_tick_nxt;
  logic [2:0] r_retry_cnt;
  logic [2:0] w_retry_base;
  logic [2:0] w_retry_inc;
  logic       r_en;
  logic       r_locked;
  logic       r_irq_en;
  logic       r_failsafe;
  logic       r_missed;
  logic       r_irq_pend;
  logic       r_sys_rst_req;
  logic       r_pwr_cycle_req;
  logic       w_bite_ok;
  logic       w_bite_missed;
  logic       w_pulse_done;
  logic       w_sel_ctrl;
  logic       w_sel_stat;
  logic       w_sel_state;
  logic       w_wr_ctrl;
  logic       w_wr_stat;
  logic       w_clr_retry;
  logic       w_pc_nxt;
  logic       w_pc_done;

  assign w_sel_ctrl  = (csr_bus.csr_a == BASE_ADDR);
  assign w_sel_stat  = (csr_bus.csr_a == BASE_ADDR + 5'd1);
  assign w_sel_state = (csr_bus.csr_a == BASE_ADDR + 5'd2);
  assign w_wr_ctrl   = csr_bus.csr_we & w_sel_ctrl & ~r_locked;
  assign w_wr_stat   = csr_bus.csr_we & w_sel_stat;
  assign w_clr_retry = w_wr_ctrl & csr_bus.csr_di[7];

  // Tick counter is checked for zero every clk so a zero load gives a one-clk phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_bite_ok    = 1'b0;
    w_pulse_done = 1'b0;
    if (i_pwr_is_off) begin
      w_state_nxt = ST_IDLE;
      w_tick_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_bite_strobe && r_en) begin
            w_state_nxt = ST_ASSERT;
            w_tick_nxt  = PULSE_TICKS;
            w_bite_ok   = 1'b1;
          end
        end
        ST_ASSERT: begin
          if (r_tick_cnt == 8'd0) begin
            w_state_nxt  = ST_HOLDOFF;
            w_tick_nxt   = HOLDOFF_TICKS;
            w_pulse_done = 1'b1;
          end else if (i_ce) begin
            w_tick_nxt = r_tick_cnt - 8'd1;
          end
        end
        ST_HOLDOFF: begin
          if (r_tick_cnt == 8'd0) begin
            w_state_nxt = ST_IDLE;
          end else if (i_ce) begin
            w_tick_nxt = r_tick_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = 8'd0;
        end
      endcase
    end
  end

  assign w_bite_missed = ~i_pwr_is_off & (r_state == ST_HOLDOFF) & i_bite_strobe;

  // A clr_retry landing with an accepted bite counts that bite from zero.
  assign w_retry_base = w_clr_retry ? 3'd0 : r_retry_cnt;
  assign w_retry_inc  = (w_retry_base == 3'd7) ? 3'd7 : w_retry_base + 3'd1;

`ifdef RSTSEQ_PWRCYCLE_EN
  logic r_pc_mode;
  logic r_pc_done;

  assign w_pc_nxt  = w_bite_ok ? r_failsafe : r_pc_mode;
  assign w_pc_done = r_pc_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_mode <= 1'b0;
      r_pc_done <= 1'b0;
    end else begin
      r_pc_mode <= w_pc_nxt;
      if (w_pulse_done && r_pc_mode) begin
        r_pc_done <= 1'b1;
      end else if (w_wr_stat && csr_bus.csr_di[6]) begin
        r_pc_done <= 1'b0;
      end
    end
  end
`else
  logic w_unused_di6;

  assign w_pc_nxt     = 1'b0;
  assign w_pc_done    = 1'b0;
  assign w_unused_di6 = csr_bus.csr_di[6];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_tick_cnt      <= 8'd0;
      r_retry_cnt     <= 3'd0;
      r_en            <= 1'b0;
      r_locked        <= 1'b0;
      r_irq_en        <= 1'b0;
      r_failsafe      <= 1'b0;
      r_missed        <= 1'b0;
      r_irq_pend      <= 1'b0;
      r_sys_rst_req   <= 1'b0;
      r_pwr_cycle_req <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tick_cnt      <= w_tick_nxt;
      r_sys_rst_req   <= (w_state_nxt == ST_ASSERT) & ~w_pc_nxt;
      r_pwr_cycle_req <= (w_state_nxt == ST_ASSERT) & w_pc_nxt;

      if (w_wr_ctrl) begin
        r_en     <= csr_bus.csr_di[0];
        r_locked <= csr_bus.csr_di[1];
        r_irq_en <= csr_bus.csr_di[2];
      end

      if (w_bite_ok) begin
        r_retry_cnt <= w_retry_inc;
      end else if (w_clr_retry) begin
        r_retry_cnt <= 3'd0;
      end

      // New events win over a same-clk w1c of the sticky bits.
      if (w_bite_ok && (w_retry_inc >= MAX_RETRIES)) begin
        r_failsafe <= 1'b1;
      end else if (w_wr_stat && csr_bus.csr_di[3] && !r_locked) begin
        r_failsafe <= 1'b0;
      end

      if (w_bite_missed) begin
        r_missed <= 1'b1;
      end else if (w_wr_stat && csr_bus.csr_di[4]) begin
        r_missed <= 1'b0;
      end

      if (w_bite_ok) begin
        r_irq_pend <= 1'b1;
      end else if (w_wr_stat && csr_bus.csr_di[5]) begin
        r_irq_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    csr_bus.csr_do = 8'h00;
    if (w_sel_ctrl) begin
      csr_bus.csr_do = {5'b00000, r_irq_en, r_locked, r_en};
    end else if (w_sel_stat) begin
      csr_bus.csr_do = {1'b0, w_pc_done, r_irq_pend, r_missed, r_failsafe, r_retry_cnt};
    end else if (w_sel_state) begin
      csr_bus.csr_do = {6'b000000, r_state};
    end
  end

  assign o_sys_rst_req   = r_sys_rst_req;
  assign o_pwr_cycle_req = r_pwr_cycle_req;
  assign o_boot_failsafe = r_failsafe;
  assign o_irq           = r_irq_pend & r_irq_en;
  assign o_dbg_state     = r_state;

endmodule
